// File: rtl/psc_tile_scheduler.sv
// Round-robin job scheduler in front of the PSC tile array, one job in flight.
// Optional WAIT timeout abort is enabled by defining PSC_SCHED_TIMEOUT_EN.
module psc_tile_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_mode,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   done,
  output logic [1:0]           psc_mode,
  output logic                 psc_start,
  input  logic                 psc_finish,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      sel_q, sel_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [1:0]         psc_mode_q, psc_mode_d;
  logic               psc_start_q, psc_start_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
`ifdef PSC_SCHED_TIMEOUT_EN
  logic [15:0]        cnt_q, cnt_d;
`endif

  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic [1:0]         pick_mode;
  int                 j;

  // First set request at or above rr_ptr, wrapping around
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!pick_vld && req[j[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = j[IW-1:0];
      end
    end
    pick_mode = req_mode[2*int'(pick_idx) +: 2];
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    done_d      = '0;
    psc_mode_d  = psc_mode_q;
    psc_start_d = 1'b0;
    busy_d      = busy_q;
    err_d       = 1'b0;
`ifdef PSC_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d    = NUM_REQ'(1) << pick_idx;
          sel_d      = pick_idx;
          busy_d     = 1'b1;
          psc_mode_d = pick_mode;
          if (pick_mode != 2'b00) begin
            psc_start_d = 1'b1;
            state_d     = S_LAUNCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_LAUNCH: begin
`ifdef PSC_SCHED_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (psc_finish) begin
          done_d  = grant_q;
          state_d = S_DONE;
`ifdef PSC_SCHED_TIMEOUT_EN
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          done_d  = grant_q;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
`endif
        end
      end
      S_DONE: begin
        // A no-op job arrives here without a done pulse; emit it first
        if (done_q == '0) begin
          done_d = grant_q;
        end else begin
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + IW'(1);
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      grant_q     <= '0;
      done_q      <= '0;
      psc_mode_q  <= 2'b00;
      psc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PSC_SCHED_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      psc_mode_q  <= psc_mode_d;
      psc_start_q <= psc_start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
`ifdef PSC_SCHED_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign psc_mode  = psc_mode_q;
  assign psc_start = psc_start_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_psc_tile_scheduler.sv
// Directed bench for psc_tile_scheduler: job table plus hand-written
// rotation, stale-finish, reset-abort and (optional) timeout sequences.
module tb_psc_tile_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic [7:0] req_mode = '0;
  logic [3:0] grant, done;
  logic [1:0] psc_mode;
  logic       psc_start, busy, err;
  logic       psc_finish = 1'b0;

  always #5 clk = ~clk;

  psc_tile_scheduler #(
    .NUM_REQ(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_mode(req_mode),
    .grant(grant),
    .done(done),
    .psc_mode(psc_mode),
    .psc_start(psc_start),
    .psc_finish(psc_finish),
    .busy(busy),
    .err(err)
  );

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      start_cnt += int'(psc_start);
      done_cnt  += int'(done != 4'b0);
      busy_cnt  += int'(busy);
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [7:0] mode;
    int         fdly;
    logic [3:0] exp_grant;
    logic [1:0] exp_mode;
    int         exp_starts;
    int         exp_busy;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output logic [3:0] g);
    int k;
    k = 0;
    while (grant != 4'b0 && k < 8) begin
      step();
      k++;
    end
    k = 0;
    while (grant == 4'b0 && k < 10) begin
      step();
      k++;
    end
    if (grant == 4'b0) begin
      total++;
      bad++;
      $display("FAIL grant_timeout actual=0 required=nonzero");
    end
    g = grant;
  endtask

  task automatic finish_job(input int fdly, output logic [3:0] d,
                            output logic e);
    int  k;
    bit  got;
    k   = 0;
    got = 1'b0;
    d   = '0;
    e   = 1'b0;
    while (k < fdly + 40 && !got) begin
      if (done != 4'b0) begin
        got = 1'b1;
        d   = done;
        e   = err;
      end else begin
        psc_finish = (k == fdly);
        step();
        k++;
      end
    end
    psc_finish = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL done_timeout actual=0 required=nonzero");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  logic [3:0] g, d;
  logic       e;
  logic [3:0] rot_exp [5];

  initial begin
    vecs[0] = '{4'b0100, 8'h20, 20, 4'b0100, 2'b10, 1, 22};
    vecs[1] = '{4'b0011, 8'h0D,  3, 4'b0001, 2'b01, 1,  5};
    vecs[2] = '{4'b1010, 8'h4C,  1, 4'b0010, 2'b11, 1,  3};
    vecs[3] = '{4'b1010, 8'h4C,  5, 4'b1000, 2'b01, 1,  7};
    vecs[4] = '{4'b1000, 8'h3F,  1, 4'b1000, 2'b00, 0,  2};
    vecs[5] = '{4'b0110, 8'h24,  2, 4'b0010, 2'b01, 1,  4};
    rot_exp[0] = 4'b0001;
    rot_exp[1] = 4'b0010;
    rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000;
    rot_exp[4] = 4'b0001;

    step();
    step();
    chk("reset_outputs",
        {22'd0, grant, done, psc_mode, psc_start, busy, err},
        32'd0);
    reset = 1'b0;
    step();

    foreach (vecs[i]) begin
      req       = vecs[i].req;
      req_mode  = vecs[i].mode;
      start_cnt = 0;
      done_cnt  = 0;
      busy_cnt  = 0;
      wait_grant(g);
      chk($sformatf("v%0d_grant", i), 32'(g), 32'(vecs[i].exp_grant));
      chk($sformatf("v%0d_mode", i), 32'(psc_mode), 32'(vecs[i].exp_mode));
      finish_job(vecs[i].fdly, d, e);
      chk($sformatf("v%0d_done", i), 32'(d), 32'(vecs[i].exp_grant));
      chk($sformatf("v%0d_err", i), 32'(e), 32'd0);
      chk($sformatf("v%0d_mode_hold", i), 32'(psc_mode),
          32'(vecs[i].exp_mode));
      req = '0;
      step();
      step();
      step();
      chk($sformatf("v%0d_starts", i), 32'(start_cnt),
          32'(vecs[i].exp_starts));
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_cnt),
          32'(vecs[i].exp_busy));
      chk($sformatf("v%0d_done_pulses", i), 32'(done_cnt), 32'd1);
    end

    do_reset();
    req       = 4'b1111;
    req_mode  = 8'h55;
    start_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      chk($sformatf("rot%0d_grant", i), 32'(g), 32'(rot_exp[i]));
      finish_job(3, d, e);
      chk($sformatf("rot%0d_done", i), 32'(d), 32'(rot_exp[i]));
    end
    req = '0;
    step();
    step();
    step();
    chk("rot_starts", 32'(start_cnt), 32'd5);

    for (int i = 0; i < 2; i++) begin
      req      = (i == 0) ? 4'b0010 : 4'b0100;
      req_mode = (i == 0) ? 8'h04 : 8'h10;
      wait_grant(g);
      chk($sformatf("stale%0d_grant", i), 32'(g), 32'(req));
      psc_finish = 1'b1;
      step();
      chk($sformatf("stale%0d_launch", i), 32'(done), 32'd0);
      step();
      chk($sformatf("stale%0d_done", i), 32'(done), 32'(req));
      req = '0;
      step();
      step();
    end
    psc_finish = 1'b0;
    step();

    req      = 4'b0100;
    req_mode = 8'h30;
    wait_grant(g);
    chk("abort_grant", 32'(g), 32'(4'b0100));
    step();
    step();
    step();
    done_cnt = 0;
    reset    = 1'b1;
    req      = '0;
    step();
    chk("abort_outputs",
        {22'd0, grant, done, psc_mode, psc_start, busy, err},
        32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    req      = 4'b1010;
    req_mode = 8'h44;
    wait_grant(g);
    chk("abort_rr_reset", 32'(g), 32'(4'b0010));
    finish_job(2, d, e);
    chk("abort_next_done", 32'(d), 32'(4'b0010));
    req = '0;
    step();
    step();

`ifdef PSC_SCHED_TIMEOUT_EN
    do_reset();
    req      = 4'b0011;
    req_mode = 8'h05;
    wait_grant(g);
    chk("tmo_grant", 32'(g), 32'(4'b0001));
    for (int i = 0; i < 8; i++) step();
    chk("tmo_early", 32'(done), 32'd0);
    step();
    chk("tmo_done", 32'(done), 32'(4'b0001));
    chk("tmo_err", 32'(err), 32'd1);
    req = 4'b0010;
    step();
    chk("tmo_err_pulse", 32'(err), 32'd0);
    wait_grant(g);
    chk("tmo_next_grant", 32'(g), 32'(4'b0010));
    finish_job(1, d, e);
    chk("tmo_next_done", 32'(d), 32'(4'b0010));
    chk("tmo_next_err", 32'(e), 32'd0);
    req = '0;
    step();
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
